frame_stream_sequencer: RTL and testbench

- Frame-level controller for the pixel processor datapath: RGB565 in, RGB565 out, valid-qualified, with a 3-bit threshold input.
- On `start`, reads one frame from the input frame buffer in raster order, with a programmable blanking gap between lines. Feeds the processor and writes its outputs to the output frame buffer.
- Tracks completion and flags a stalled pipeline.
- Sits between the frame-buffer RAMs and the processor; the top-level system control issues `start` per frame.

---
 rtl/frame_stream_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_frame_stream_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_sequencer.sv
// Frame-level sequencer: raster-reads the input buffer into the pixel processor
// and writes processor results to the output buffer. Watchdog guards the drain.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing reads, one pixel per cycle unless hold
// BLANK | inter-line gap, no reads
// DRAIN | all reads issued, collecting remaining processor outputs
// DONE  | single-cycle completion pulse
module frame_stream_sequencer #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17,
    parameter int BLANK  = 4,
    parameter int WDOG   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        threshold_cfg,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       frame_cnt,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic [15:0]       proc_pixel,
    output logic              proc_valid,
    output logic [2:0]        proc_threshold,
    input  logic [15:0]       proc_pixel_out,
    input  logic              proc_valid_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_BLANK = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BW    = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam int WW    = (WDOG > 1)  ? $clog2(WDOG)  : 1;

    localparam logic [XW-1:0]     X_LAST     = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_LAST     = YW'(IMG_H - 1);
    localparam logic [ADDR_W:0]   WR_TOTAL   = (ADDR_W + 1)'(TOTAL);
    localparam logic [ADDR_W:0]   WR_LAST    = (ADDR_W + 1)'(TOTAL - 1);
    localparam logic [BW-1:0]     BLANK_LOAD = BW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [WW-1:0]     WD_LOAD    = WW'((WDOG > 0) ? WDOG - 1 : 0);

    state_t              state;
    state_t              state_nxt;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [ADDR_W:0]     wr_cnt;
    logic [BW-1:0]       blank_tmr;
    logic [WW-1:0]       wd_tmr;
    logic [15:0]         pix_hold;

    logic                accept;
    logic                fetch_go;
    logic                line_end;
    logic                last_line;
    logic                active;
    logic                wr_take;
    logic                wr_final;
    logic                wd_trip;

    always_comb begin
        accept    = (state == S_IDLE) && start;
        fetch_go  = (state == S_FETCH) && !hold;
        line_end  = fetch_go && (x == X_LAST);
        last_line = (y == Y_LAST);
        active    = (state == S_FETCH) || (state == S_BLANK) || (state == S_DRAIN);
        wr_take   = active && proc_valid_out && (wr_cnt < WR_TOTAL);
        wr_final  = wr_take && (wr_cnt == WR_LAST);
        wd_trip   = (state == S_DRAIN) && !proc_valid_out && (wd_tmr == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion of the write side wins over any read-side transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (wr_final) begin
                    state_nxt = S_DONE;
                end else if (line_end) begin
                    if (last_line) begin
                        state_nxt = S_DRAIN;
                    end else if (BLANK > 0) begin
                        state_nxt = S_BLANK;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_BLANK: begin
                if (wr_final) begin
                    state_nxt = S_DONE;
                end else if (blank_tmr == '0) begin
                    state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (wr_final || wd_trip) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_en = fetch_go;
        busy  = (state != S_IDLE);
        done  = (state == S_DONE);
    end

    // Raster position and read address; the address stops on the last pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x              <= '0;
            y              <= '0;
            rd_addr        <= '0;
            proc_threshold <= '0;
        end else if (accept) begin
            x              <= '0;
            y              <= '0;
            rd_addr        <= '0;
            proc_threshold <= threshold_cfg;
        end else if (fetch_go) begin
            if (x == X_LAST) begin
                if (!last_line) begin
                    x       <= '0;
                    y       <= y + YW'(1);
                    rd_addr <= rd_addr + ADDR_W'(1);
                end
            end else begin
                x       <= x + XW'(1);
                rd_addr <= rd_addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_tmr <= '0;
            wd_tmr    <= '0;
        end else begin
            if (state == S_BLANK) begin
                if (blank_tmr != '0) begin
                    blank_tmr <= blank_tmr - BW'(1);
                end
            end else begin
                blank_tmr <= BLANK_LOAD;
            end

            if ((state == S_DRAIN) && !proc_valid_out) begin
                if (wd_tmr != '0) begin
                    wd_tmr <= wd_tmr - WW'(1);
                end
            end else begin
                wd_tmr <= WD_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (accept) begin
                err <= 1'b0;
            end else if (wd_trip) begin
                err <= 1'b1;
            end
            if (state == S_DONE) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // The buffer returns data one cycle after rd_en, so the pixel is taken
    // straight from rd_data while valid and held from the register otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proc_valid <= 1'b0;
            pix_hold   <= '0;
        end else begin
            proc_valid <= rd_en;
            if (proc_valid) begin
                pix_hold <= rd_data;
            end
        end
    end

    always_comb begin
        proc_pixel = proc_valid ? rd_data : pix_hold;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_cnt  <= '0;
        end else if (accept) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_cnt  <= '0;
        end else begin
            wr_en <= wr_take;
            if (wr_take) begin
                wr_addr <= wr_cnt[ADDR_W-1:0];
                wr_data <= proc_pixel_out;
                wr_cnt  <= wr_cnt + (ADDR_W + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_stream_sequencer.sv
// Bench for frame_stream_sequencer: cycle table for nominal and held frames,
// plus directed watchdog, reset and back-to-back (no blanking) sequences.
module tb_frame_stream_sequencer;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 2;
    localparam int ADDR_W = 3;
    localparam int WDOG   = 8;
    localparam int TOTAL  = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              start_a, hold_a;
    logic [2:0]        thr_a;
    logic              busy_a, done_a, err_a;
    logic [15:0]       fcnt_a;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [15:0]       rd_data_a;
    logic [15:0]       pp_a;
    logic              pv_a;
    logic [2:0]        pthr_a;
    logic [15:0]       ppo_a;
    logic              pvo_a;
    logic              wr_en_a;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [15:0]       wr_data_a;

    logic              start_b, hold_b;
    logic [2:0]        thr_b;
    logic              busy_b, done_b, err_b;
    logic [15:0]       fcnt_b;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [15:0]       rd_data_b;
    logic [15:0]       pp_b;
    logic              pv_b;
    logic [2:0]        pthr_b;
    logic [15:0]       ppo_b;
    logic              pvo_b;
    logic              wr_en_b;
    logic [ADDR_W-1:0] wr_addr_b;
    logic [15:0]       wr_data_b;

    frame_stream_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .BLANK(2), .WDOG(WDOG)) dut (
        .clk(clk), .rst(rst), .start(start_a), .threshold_cfg(thr_a), .hold(hold_a),
        .busy(busy_a), .done(done_a), .err(err_a), .frame_cnt(fcnt_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .proc_pixel(pp_a), .proc_valid(pv_a), .proc_threshold(pthr_a),
        .proc_pixel_out(ppo_a), .proc_valid_out(pvo_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
    );

    frame_stream_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .BLANK(0), .WDOG(WDOG)) dut_nb (
        .clk(clk), .rst(rst), .start(start_b), .threshold_cfg(thr_b), .hold(hold_b),
        .busy(busy_b), .done(done_b), .err(err_b), .frame_cnt(fcnt_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .proc_pixel(pp_b), .proc_valid(pv_b), .proc_threshold(pthr_b),
        .proc_pixel_out(ppo_b), .proc_valid_out(pvo_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
    );

    function automatic logic [15:0] mem_val(input logic [ADDR_W-1:0] a);
        return 16'h3C00 ^ {a, a, a, a, 4'h7};
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Input buffers: registered read, one cycle latency.
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= mem_val(rd_addr_a);
        if (rd_en_b) rd_data_b <= mem_val(rd_addr_b);
    end

    // Processor models: one-cycle pass-through; model A can drop trailing outputs.
    int drop_from = TOTAL;
    int in_cnt_a  = 0;
    always @(posedge clk) begin
        if (start_a && !busy_a) in_cnt_a <= 0;
        else if (pv_a)          in_cnt_a <= in_cnt_a + 1;
        pvo_a <= pv_a && (in_cnt_a < drop_from);
        ppo_a <= pp_a;
        pvo_b <= pv_b;
        ppo_b <= pp_b;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wr_cnt_a = 0, done_cnt_a = 0, wr_cnt_b = 0, done_cnt_b = 0;
    int last_pvo_cyc = 0, run_b = 0, max_run_b = 0;
    always @(negedge clk) begin
        if (wr_en_a) begin
            wr_cnt_a++;
            chk("wr_data_a", int'(wr_data_a), int'(mem_val(wr_addr_a)));
        end
        if (wr_en_b) begin
            wr_cnt_b++;
            chk("wr_data_b", int'(wr_data_b), int'(mem_val(wr_addr_b)));
        end
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (pvo_a) last_pvo_cyc = cyc;
        if (rd_en_b) begin
            run_b++;
            if (run_b > max_run_b) max_run_b = run_b;
        end else begin
            run_b = 0;
        end
    end

    typedef struct {
        bit start; bit hold;
        bit rd;    int ra;
        bit wr;    int wa;
        bit busy;  bit done;
        int thr;
    } vec_t;

    vec_t vecs[33];

    initial begin
        int n;
        bit found;

        // Nominal frame, threshold 5.
        vecs[0]  = '{1,0, 0,0, 0,0, 0,0, 0};
        vecs[1]  = '{0,0, 1,0, 0,0, 1,0, 5};
        vecs[2]  = '{0,0, 1,1, 0,0, 1,0, 5};
        vecs[3]  = '{0,0, 1,2, 0,0, 1,0, 5};
        vecs[4]  = '{0,0, 1,3, 1,0, 1,0, 5};
        vecs[5]  = '{0,0, 0,0, 1,1, 1,0, 5};
        vecs[6]  = '{0,0, 0,0, 1,2, 1,0, 5};
        vecs[7]  = '{0,0, 1,4, 1,3, 1,0, 5};
        vecs[8]  = '{0,0, 1,5, 0,0, 1,0, 5};
        vecs[9]  = '{0,0, 1,6, 0,0, 1,0, 5};
        vecs[10] = '{0,0, 1,7, 1,4, 1,0, 5};
        vecs[11] = '{0,0, 0,0, 1,5, 1,0, 5};
        vecs[12] = '{0,0, 0,0, 1,6, 1,0, 5};
        vecs[13] = '{0,0, 0,0, 1,7, 1,1, 5};
        vecs[14] = '{0,0, 0,0, 0,0, 0,0, 5};
        // Held frame: hold 3 cycles at x=2 of line 0, and hold during the blank gap.
        vecs[15] = '{1,0, 0,0, 0,0, 0,0, 5};
        vecs[16] = '{0,0, 1,0, 0,0, 1,0, 5};
        vecs[17] = '{0,0, 1,1, 0,0, 1,0, 5};
        vecs[18] = '{0,1, 0,0, 0,0, 1,0, 5};
        vecs[19] = '{0,1, 0,0, 1,0, 1,0, 5};
        vecs[20] = '{0,1, 0,0, 1,1, 1,0, 5};
        vecs[21] = '{0,0, 1,2, 0,0, 1,0, 5};
        vecs[22] = '{0,0, 1,3, 0,0, 1,0, 5};
        vecs[23] = '{0,1, 0,0, 0,0, 1,0, 5};
        vecs[24] = '{0,1, 0,0, 1,2, 1,0, 5};
        vecs[25] = '{0,0, 1,4, 1,3, 1,0, 5};
        vecs[26] = '{0,0, 1,5, 0,0, 1,0, 5};
        vecs[27] = '{0,0, 1,6, 0,0, 1,0, 5};
        vecs[28] = '{0,0, 1,7, 1,4, 1,0, 5};
        vecs[29] = '{0,0, 0,0, 1,5, 1,0, 5};
        vecs[30] = '{0,0, 0,0, 1,6, 1,0, 5};
        vecs[31] = '{0,0, 0,0, 1,7, 1,1, 5};
        vecs[32] = '{0,0, 0,0, 0,0, 0,0, 5};

        start_a = 1'b0; hold_a = 1'b0; thr_a = 3'd0;
        start_b = 1'b0; hold_b = 1'b0; thr_b = 3'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs_zero",
            int'(|{busy_a, done_a, err_a, fcnt_a, rd_en_a, rd_addr_a, pp_a, pv_a,
                   pthr_a, wr_en_a, wr_addr_a, wr_data_a}), 0);

        for (int i = 0; i < 33; i++) begin
            @(posedge clk);
            #1;
            start_a = vecs[i].start;
            hold_a  = vecs[i].hold;
            thr_a   = vecs[i].start ? 3'd5 : 3'd6;
            @(negedge clk);
            chk($sformatf("row%0d_rd_en", i), int'(rd_en_a), int'(vecs[i].rd));
            if (vecs[i].rd) chk($sformatf("row%0d_rd_addr", i), int'(rd_addr_a), vecs[i].ra);
            chk($sformatf("row%0d_wr_en", i), int'(wr_en_a), int'(vecs[i].wr));
            if (vecs[i].wr) chk($sformatf("row%0d_wr_addr", i), int'(wr_addr_a), vecs[i].wa);
            chk($sformatf("row%0d_busy", i), int'(busy_a), int'(vecs[i].busy));
            chk($sformatf("row%0d_done", i), int'(done_a), int'(vecs[i].done));
            chk($sformatf("row%0d_thr", i), int'(pthr_a), vecs[i].thr);
        end
        start_a = 1'b0; hold_a = 1'b0;
        chk("table_frame_cnt", int'(fcnt_a), 2);
        chk("table_done_cnt", done_cnt_a, 2);
        chk("table_wr_cnt", wr_cnt_a, 16);
        chk("table_err", int'(err_a), 0);

        // Watchdog: last two processor outputs never arrive.
        drop_from = 6; wr_cnt_a = 0; done_cnt_a = 0;
        @(posedge clk); #1 start_a = 1'b1; thr_a = 3'd3;
        @(posedge clk); #1 start_a = 1'b0; thr_a = 3'd0;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done_a) break;
        end
        chk("wd_done_seen", int'(done_a), 1);
        chk("wd_err_at_done", int'(err_a), 1);
        chk("wd_idle_gap", cyc - last_pvo_cyc, WDOG + 1);
        chk("wd_threshold", int'(pthr_a), 3);
        chk("wd_wr_cnt", wr_cnt_a, 6);
        repeat (2) @(negedge clk);
        chk("wd_err_sticky", int'(err_a), 1);
        chk("wd_frame_cnt", int'(fcnt_a), 3);
        chk("wd_busy_after", int'(busy_a), 0);

        // Next start clears err; a start pulsed during FETCH is ignored.
        drop_from = TOTAL; wr_cnt_a = 0; done_cnt_a = 0;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        @(negedge clk);
        chk("err_cleared_on_start", int'(err_a), 0);
        chk("busy_after_start", int'(busy_a), 1);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (40) @(negedge clk);
        chk("restart_done_cnt", done_cnt_a, 1);
        chk("restart_wr_cnt", wr_cnt_a, 8);
        chk("restart_frame_cnt", int'(fcnt_a), 4);
        chk("restart_err", int'(err_a), 0);

        // Reset at y=1, x=1 abandons the frame.
        done_cnt_a = 0;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        found = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rd_en_a && (rd_addr_a == 3'd5)) begin
                found = 1'b1;
                break;
            end
        end
        chk("midreset_reached_x1y1", int'(found), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset_outputs_zero",
            int'(|{busy_a, done_a, err_a, fcnt_a, rd_en_a, rd_addr_a, pp_a, pv_a,
                   pthr_a, wr_en_a, wr_addr_a, wr_data_a}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("midreset_no_done", done_cnt_a, 0);
        wr_cnt_a = 0;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_reset_done_cnt", done_cnt_a, 1);
        chk("post_reset_wr_cnt", wr_cnt_a, 8);
        chk("post_reset_frame_cnt", int'(fcnt_a), 1);

        // No-blank instance: back-to-back frames, start during DONE ignored.
        thr_b = 3'd7;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done_b) break;
        end
        chk("nb_first_done", int'(done_b), 1);
        start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        @(negedge clk);
        chk("nb_start_in_done_ignored", int'(busy_b), 0);
        start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done_b) break;
        end
        chk("nb_second_done", int'(done_b), 1);
        @(negedge clk);
        chk("nb_frame_cnt", int'(fcnt_b), 2);
        chk("nb_done_cnt", done_cnt_b, 2);
        chk("nb_wr_cnt", wr_cnt_b, 16);
        chk("nb_max_rd_run", max_run_b, 8);
        chk("nb_threshold", int'(pthr_b), 7);
        chk("nb_err", int'(err_b), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
